fir_seq_ctrl: RTL and testbench

//  Sequencer and configuration controller for the fir_csm tap datapath. Takes samples over valid/ready,

---
 rtl/fir_seq_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// Sample sequencer, result FIFO and coefficient bank for the fir_csm tap datapath.
// Define FIR_ROUND_SAT_EN to round/saturate results to 16 bits at FIFO push.
module fir_seq_ctrl #(
  parameter int N      = 4,
  parameter int LAT    = 3,
  parameter int RDEPTH = 4,
  parameter int DW     = 16,
  parameter int CW     = 17,
  parameter int OW     = 32,
  parameter int AW     = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [DW-1:0]   s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [OW-1:0]   m_data,
  input  logic            cfg_we,
  input  logic [AW-1:0]   cfg_addr,
  input  logic [CW-1:0]   cfg_data,
  output logic            cfg_err,
  input  logic            flush_req,
  output logic            busy,
  output logic            fir_data_valid,
  output logic [DW-1:0]   fir_x_in,
  input  logic [OW-1:0]   fir_y_in,
  output logic [N*CW-1:0] coeff_bus
);
  localparam int CNTW = $clog2(RDEPTH + 1);
  localparam int PW   = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam int ZW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] COEFF_RST = CW'(17'h04000);
`ifdef FIR_ROUND_SAT_EN
  localparam logic signed [OW:0] RND    = (OW+1)'(32768);
  localparam logic signed [OW:0] SAT_HI = (OW+1)'(32767);
  localparam logic signed [OW:0] SAT_LO = -((OW+1)'(32768));
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH_WAIT, FLUSH_ZERO} state_t;

  state_t             state_q, state_d;
  logic [LAT:0]       tag_vld_q, tag_vld_d;
  logic [LAT:0]       tag_dis_q, tag_dis_d;
  logic               dv_q, dv_d;
  logic [DW-1:0]      x_q, x_d;
  logic [OW-1:0]      mem_q [RDEPTH];
  logic [OW-1:0]      mem_d [RDEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]    count_q, count_d, inflight_q, inflight_d;
  logic [ZW-1:0]      zcnt_q, zcnt_d;
  logic [N*CW-1:0]    coeff_q, coeff_d;
  logic               cfg_err_q, cfg_err_d;
  logic [CNTW:0]      credit;
  logic               accept, zero_issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [OW-1:0] shape(input logic [OW-1:0] y);
`ifdef FIR_ROUND_SAT_EN
    logic signed [OW:0] r;
    r = ($signed({y[OW-1], y}) + RND) >>> 16;
    if (r > SAT_HI)      return OW'(SAT_HI);
    else if (r < SAT_LO) return OW'(SAT_LO);
    else                 return OW'(r);
`else
    return y;
`endif
  endfunction

  always_comb begin
    // Credit uses registered counts only, so m_ready never reaches s_ready.
    credit     = {1'b0, inflight_q} + {1'b0, count_q};
    s_ready    = ((state_q == IDLE) || (state_q == RUN)) && !flush_req &&
                 (credit < (CNTW+1)'(RDEPTH));
    accept     = s_valid && s_ready;
    zero_issue = (state_q == FLUSH_ZERO);
    push       = tag_vld_q[LAT] && !tag_dis_q[LAT];
    m_valid    = (count_q != '0);
    pop        = m_valid && m_ready;
    m_data     = mem_q[rd_ptr_q];
    busy       = (state_q != IDLE);

    dv_d      = accept || zero_issue;
    x_d       = accept ? s_data : '0;
    tag_vld_d = {tag_vld_q[LAT-1:0], accept || zero_issue};
    tag_dis_d = {tag_dis_q[LAT-1:0], zero_issue};

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = shape(fir_y_in);
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    inflight_d = inflight_q;
    case ({accept, push})
      2'b10:   inflight_d = inflight_q + CNTW'(1);
      2'b01:   inflight_d = inflight_q - CNTW'(1);
      default: inflight_d = inflight_q;
    endcase

    state_d = state_q;
    zcnt_d  = zcnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req)   state_d = FLUSH_WAIT;
        else if (accept) state_d = RUN;
      end
      RUN: begin
        if (flush_req) state_d = FLUSH_WAIT;
        else if (inflight_q == '0 && count_q == '0 && !accept) state_d = IDLE;
      end
      FLUSH_WAIT: begin
        if (tag_vld_q == '0) begin
          state_d = FLUSH_ZERO;
          zcnt_d  = '0;
        end
      end
      FLUSH_ZERO: begin
        zcnt_d = zcnt_q + ZW'(1);
        if (zcnt_q == ZW'(N - 1)) state_d = (count_d != '0) ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    coeff_d   = coeff_q;
    cfg_err_d = 1'b0;
    if (cfg_we) begin
      if (state_q == IDLE && cfg_addr < AW'(N)) begin
        for (int unsigned i = 0; i < N; i++)
          if (cfg_addr == AW'(i)) coeff_d[i*CW +: CW] = cfg_data;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tag_vld_q  <= '0;
      tag_dis_q  <= '0;
      dv_q       <= 1'b0;
      x_q        <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      zcnt_q     <= '0;
      coeff_q    <= {N{COEFF_RST}};
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_vld_q  <= tag_vld_d;
      tag_dis_q  <= tag_dis_d;
      dv_q       <= dv_d;
      x_q        <= x_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      zcnt_q     <= zcnt_d;
      coeff_q    <= coeff_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign fir_data_valid = dv_q;
  assign fir_x_in       = x_q;
  assign cfg_err        = cfg_err_q;
  assign coeff_bus      = coeff_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl with a behavioural N-tap, LAT-cycle filter model.
module tb_fir_seq_ctrl;
  localparam int N = 4, LAT = 3, RDEPTH = 4, DW = 16, CW = 17, OW = 32, AW = 3;

  logic            clk, rst;
  logic            s_valid, s_ready, m_valid, m_ready;
  logic [DW-1:0]   s_data;
  logic [OW-1:0]   m_data;
  logic            cfg_we, cfg_err, flush_req, busy, fir_data_valid;
  logic [AW-1:0]   cfg_addr;
  logic [CW-1:0]   cfg_data;
  logic [DW-1:0]   fir_x_in;
  logic [OW-1:0]   fir_y_in;
  logic [N*CW-1:0] coeff_bus;

  fir_seq_ctrl #(.N(N), .LAT(LAT), .RDEPTH(RDEPTH), .DW(DW), .CW(CW), .OW(OW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err), .flush_req(flush_req),
    .busy(busy), .fir_data_valid(fir_data_valid), .fir_x_in(fir_x_in),
    .fir_y_in(fir_y_in), .coeff_bus(coeff_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int acc_cyc = 0, lat_cyc = 0;
  bit lat_arm = 1'b0, zcount_en = 1'b0;
  int zcnt = 0;
  logic [OW-1:0] exp_q [$];

  always @(posedge clk) cyc = cyc + 1;

  // Filter model: y = sum c[i]*x[n-i], presented LAT edges after data_valid is sampled.
  logic [DW-1:0] hist [N];
  logic [OW-1:0] ypipe [LAT];
  assign fir_y_in = ypipe[LAT-1];
  always @(posedge clk or posedge rst) begin : filt
    longint acc;
    if (rst) begin
      for (int i = 0; i < N; i++) hist[i] <= '0;
      for (int i = 0; i < LAT; i++) ypipe[i] <= '0;
    end else begin
      acc = longint'($signed(fir_x_in)) * longint'($signed(coeff_bus[CW-1:0]));
      for (int i = 1; i < N; i++)
        acc += longint'($signed(hist[i-1])) * longint'($signed(coeff_bus[i*CW +: CW]));
      ypipe[0] <= fir_data_valid ? OW'(acc) : OW'(32'hDEADBEEF);
      for (int i = 1; i < LAT; i++) ypipe[i] <= ypipe[i-1];
      if (fir_data_valid) begin
        hist[0] <= fir_x_in;
        for (int i = 1; i < N; i++) hist[i] <= hist[i-1];
      end
    end
  end

  always @(posedge clk) if (zcount_en && fir_data_valid && fir_x_in == '0) zcnt++;

  function automatic logic [OW-1:0] fmt(input logic [OW-1:0] raw);
`ifdef FIR_ROUND_SAT_EN
    longint v;
    v = (longint'($signed(raw)) + 32768) >>> 16;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return OW'(v);
`else
    return raw;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is handed over.
  always @(negedge clk) begin
    if (!rst) begin
      if (lat_arm && m_valid) begin
        lat_arm = 1'b0;
        check("accept_to_m_valid_edges", cyc - lat_cyc + 1, LAT + 2);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got=%0h want=none", m_data);
        end else begin
          check("m_data", m_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic [OW-1:0] raw);
    int unsigned w;
    w = 0;
    s_valid = 1'b1; s_data = d;
    @(negedge clk);
    while (!s_ready && w < 50) begin @(negedge clk); w++; end
    if (!s_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: got=s_ready_low want=accept");
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    exp_q.push_back(fmt(raw));
    s_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned w;
    w = 0;
    while ((exp_q.size() != 0 || busy) && w < 100) begin @(negedge clk); w++; end
    check({name, "_drain"}, (exp_q.size() == 0) && !busy, 1);
    @(posedge clk); #1;
  endtask

  logic [N*CW-1:0] def_bus, exp_bus;
  logic [DW-1:0]   bp_x   [4] = '{16'd10, 16'd20, 16'd30, 16'd40};
  logic [OW-1:0]   bp_y   [4] = '{32'd163840, 32'd491520, 32'd983040, 32'd1638400};
  int n, mv_seen;
  bit acc_now;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; flush_req = 1'b0;
    def_bus = {N{17'h04000}};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_coeff_bus", coeff_bus, def_bus);
    check("rst_s_ready", s_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fir_data_valid", fir_data_valid, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_m_data", m_data, 0);

    // Impulse response through 0.25 taps
    m_ready = 1'b1;
    send(16'd1000, 32'd16384000);
    lat_cyc = acc_cyc; lat_arm = 1'b1;
    repeat (3) send(16'd0, 32'd16384000);
    drain("impulse");
    check("latency_checked", lat_arm, 0);

    // Backpressure: credit limit stops acceptance at RDEPTH
    m_ready = 1'b0; n = 0;
    s_valid = 1'b1; s_data = bp_x[0];
    repeat (10) begin
      @(negedge clk); acc_now = s_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        if (n < 4) exp_q.push_back(fmt(bp_y[n]));
        n++;
        if (n < 4) s_data = bp_x[n];
      end
    end
    s_valid = 1'b0;
    check("bp_accepted", n, 4);
    check("bp_s_ready_low", s_ready, 0);
    check("bp_m_valid", m_valid, 1);
    m_ready = 1'b1;
    drain("backpressure");
    check("bp_s_ready_back", s_ready, 1);

    // Flush with two in flight; a concurrent s_valid must lose
    send(16'd1, 32'd1490944);
    send(16'd2, 32'd1196032);
    zcnt = 0; zcount_en = 1'b1;
    flush_req = 1'b1; s_valid = 1'b1; s_data = 16'd55;
    #1 check("flush_s_ready", s_ready, 0);
    @(posedge clk); #1;
    flush_req = 1'b0; s_valid = 1'b0;
    check("flush_busy", busy, 1);
    check("flush_state_s_ready", s_ready, 0);
    drain("flush");
    repeat (8) @(negedge clk);
    zcount_en = 1'b0;
    check("flush_zero_pulses", zcnt, N);
    @(posedge clk); #1;

    // Coefficient writes
    cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 17'h08000;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    exp_bus = def_bus; exp_bus[2*CW +: CW] = 17'h08000;
    check("cfg_idle_write", coeff_bus, exp_bus);
    check("cfg_idle_no_err", cfg_err, 0);
    send(16'd100, 32'd1638400);
    cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 17'h1FFFF;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_busy_err", cfg_err, 1);
    check("cfg_busy_bus", coeff_bus, exp_bus);
    @(posedge clk); #1;
    check("cfg_err_one_cycle", cfg_err, 0);
    drain("cfg");
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 17'h0AAAA;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("cfg_range_err", cfg_err, 1);
    check("cfg_range_bus", coeff_bus, exp_bus);

    // Reset mid-RUN with three in flight
    m_ready = 1'b0;
    send(16'd5, 32'd0); send(16'd6, 32'd0); send(16'd7, 32'd0);
    rst = 1'b1; #1;
    exp_q.delete();
    check("midrst_coeff_bus", coeff_bus, def_bus);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fir_data_valid", fir_data_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; m_ready = 1'b1; mv_seen = 0;
    repeat (12) begin @(negedge clk); if (m_valid) mv_seen++; end
    check("midrst_no_m_valid", mv_seen, 0);
    check("midrst_s_ready", s_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule
